// File: rtl/alu_operand_loader.sv
// Serial operand loader: shifts A, B and opcode in MSB-first, then holds them for the ALU until op_ready.
// Optional ALU_LOADER_PARITY_EN appends an even-parity bit to each 8-bit operand field.
module alu_operand_loader (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       op_ready,
    output logic [7:0] a_out,
    output logic [7:0] b_out,
    output logic [2:0] op_out,
    output logic       op_valid,
    output logic       busy,
    output logic       err,
    output logic [2:0] state_out
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_A  = 3'd1,
        LOAD_B  = 3'd2,
        LOAD_OP = 3'd3,
        ISSUE   = 3'd4,
        ERR     = 3'd5
    } state_t;

`ifdef ALU_LOADER_PARITY_EN
    localparam logic [3:0] OPND_LAST = 4'd8;
`else
    localparam logic [3:0] OPND_LAST = 4'd7;
`endif
    localparam logic [3:0] OPC_LAST = 4'd2;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [7:0] sr_a;
    logic [7:0] sr_b;
    logic [2:0] sr_op;
    logic       loading;
    logic       field_last;
    logic       data_bit;
    logic       par_bad;

    assign loading    = (state == LOAD_A) || (state == LOAD_B) || (state == LOAD_OP);
    assign field_last = bit_valid && (cnt == ((state == LOAD_OP) ? OPC_LAST : OPND_LAST));
    // Position 8 of an operand field is the parity bit; it is checked, never shifted in.
    assign data_bit   = (cnt < 4'd8);

`ifdef ALU_LOADER_PARITY_EN
    assign par_bad = ^{((state == LOAD_A) ? sr_a : sr_b), bit_in};
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD_A;
            LOAD_A:  if (field_last) state_nxt = par_bad ? ERR : LOAD_B;
            LOAD_B:  if (field_last) state_nxt = par_bad ? ERR : LOAD_OP;
            LOAD_OP: if (field_last) state_nxt = ISSUE;
            ISSUE:   if (op_ready) state_nxt = IDLE;
            ERR:     if (start) state_nxt = LOAD_A;
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        busy      = loading;
        op_valid  = (state == ISSUE);
`ifdef ALU_LOADER_PARITY_EN
        err       = (state == ERR);
`else
        err       = 1'b0;
`endif
        state_out = state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= 4'd0;
            sr_a   <= 8'd0;
            sr_b   <= 8'd0;
            sr_op  <= 3'd0;
            a_out  <= 8'd0;
            b_out  <= 8'd0;
            op_out <= 3'd0;
        end else if (abort) begin
            cnt <= 4'd0;
        end else begin
            if (((state == IDLE) || (state == ERR)) && start) begin
                cnt   <= 4'd0;
                sr_a  <= 8'd0;
                sr_b  <= 8'd0;
                sr_op <= 3'd0;
            end
            if (loading && bit_valid) begin
                cnt <= field_last ? 4'd0 : cnt + 4'd1;
                if ((state == LOAD_A) && data_bit) sr_a <= {sr_a[6:0], bit_in};
                if ((state == LOAD_B) && data_bit) sr_b <= {sr_b[6:0], bit_in};
                if (state == LOAD_OP) sr_op <= {sr_op[1:0], bit_in};
                if ((state == LOAD_OP) && field_last) begin
                    a_out  <= sr_a;
                    b_out  <= sr_b;
                    op_out <= {sr_op[1:0], bit_in};
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_loader.sv
// Randomized self-checking bench for alu_operand_loader; reference is the last-issued operand triple.
module tb_alu_operand_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       op_ready = 1'b0;
    logic [7:0] a_out;
    logic [7:0] b_out;
    logic [2:0] op_out;
    logic       op_valid;
    logic       busy;
    logic       err;
    logic [2:0] state_out;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_a = 8'd0;
    logic [7:0] exp_b = 8'd0;
    logic [2:0] exp_op = 3'd0;
    bit         track = 1'b0;
    bit         rnd_ready = 1'b0;
    logic [2:0] seq[$];

    alu_operand_loader dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .bit_in(bit_in), .bit_valid(bit_valid), .op_ready(op_ready),
        .a_out(a_out), .b_out(b_out), .op_out(op_out), .op_valid(op_valid),
        .busy(busy), .err(err), .state_out(state_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        if (track && (seq.size() == 0 || seq[$] !== state_out)) seq.push_back(state_out);
    endtask

    task automatic send_bit(input logic b, input int gap);
        for (int i = 0; i < gap; i++) begin
            bit_in = 1'($urandom_range(0, 1));
            if (rnd_ready) op_ready = 1'($urandom_range(0, 1));
            step();
        end
        bit_in = b;
        bit_valid = 1'b1;
        if (rnd_ready) op_ready = 1'($urandom_range(0, 1));
        step();
        bit_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] v, input int n, input int maxgap);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i], int'($urandom_range(0, maxgap)));
    endtask

    task automatic send_operand(input logic [7:0] v, input int maxgap);
        send_bits(v, 8, maxgap);
`ifdef ALU_LOADER_PARITY_EN
        send_bit(^v, int'($urandom_range(0, maxgap)));
`endif
    endtask

    // Full frame from IDLE; on return the final opcode bit has just been accepted.
    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input int maxgap);
        start = 1'b1;
        step();
        start = 1'b0;
        send_operand(a, maxgap);
        send_operand(b, maxgap);
        send_bits({5'd0, op}, 3, maxgap);
        exp_a = a;
        exp_b = b;
        exp_op = op;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        tests++;
        if ({a_out, b_out, op_out, op_valid, busy, err, state_out} !== 25'd0) begin
            fails++;
            $display("FAIL reset_state: got a=%h b=%h op=%0d vld=%b busy=%b err=%b st=%0d, want all 0",
                     a_out, b_out, op_out, op_valid, busy, err, state_out);
        end
    endtask

    task automatic test_basic();
        op_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        tests++;
        if ({busy, state_out} !== {1'b1, 3'd1}) begin
            fails++;
            $display("FAIL basic_start: got busy=%b st=%0d, want busy=1 st=1", busy, state_out);
        end
        send_operand(8'hA5, 0);
        send_operand(8'h3C, 0);
        send_bits(8'h00, 3, 0);
        exp_a = 8'hA5; exp_b = 8'h3C; exp_op = 3'd0;
        for (int c = 0; c < 6; c++) begin
            tests++;
            if ({a_out, b_out, op_out, op_valid, busy, state_out} !== {8'hA5, 8'h3C, 3'd0, 1'b1, 1'b0, 3'd4}) begin
                fails++;
                $display("FAIL basic_issue_hold%0d: got a=%h b=%h op=%0d vld=%b st=%0d, want a=a5 b=3c op=0 vld=1 st=4",
                         c, a_out, b_out, op_out, op_valid, state_out);
            end
            if (c < 5) step();
        end
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        tests++;
        if ({op_valid, state_out, a_out, b_out} !== {1'b0, 3'd0, 8'hA5, 8'h3C}) begin
            fails++;
            $display("FAIL basic_accept: got vld=%b st=%0d a=%h b=%h, want vld=0 st=0 a=a5 b=3c",
                     op_valid, state_out, a_out, b_out);
        end
    endtask

    task automatic test_gapped();
        seq.delete();
        seq.push_back(state_out);
        track = 1'b1;
        send_frame(8'hFF, 8'h01, 3'b101, 3);
        track = 1'b0;
        tests++;
        if ({a_out, b_out, op_out, op_valid} !== {8'hFF, 8'h01, 3'b101, 1'b1}) begin
            fails++;
            $display("FAIL gapped_issue: got a=%h b=%h op=%0d vld=%b, want a=ff b=01 op=5 vld=1",
                     a_out, b_out, op_out, op_valid);
        end
        tests++;
        if (seq.size() != 5 || seq[0] !== 3'd0 || seq[1] !== 3'd1 || seq[2] !== 3'd2 || seq[3] !== 3'd3 || seq[4] !== 3'd4) begin
            fails++;
            $display("FAIL gapped_state_seq: got %0d entries %p, want 0,1,2,3,4", seq.size(), seq);
        end
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
    endtask

    task automatic test_abort();
        send_frame(8'h11, 8'h22, 3'b010, 1);
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        send_operand(8'h80, 1);
        send_bits(8'hF0, 4, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        tests++;
        if ({state_out, op_valid, busy, a_out, b_out, op_out} !== {3'd0, 1'b0, 1'b0, 8'h11, 8'h22, 3'b010}) begin
            fails++;
            $display("FAIL abort_mid_b: got st=%0d vld=%b busy=%b a=%h b=%h op=%0d, want st=0 vld=0 busy=0 a=11 b=22 op=2",
                     state_out, op_valid, busy, a_out, b_out, op_out);
        end
        send_frame(8'h5A, 8'hC3, 3'b110, 2);
        tests++;
        if ({a_out, b_out, op_out, op_valid} !== {8'h5A, 8'hC3, 3'b110, 1'b1}) begin
            fails++;
            $display("FAIL abort_reframe: got a=%h b=%h op=%0d vld=%b, want a=5a b=c3 op=6 vld=1",
                     a_out, b_out, op_out, op_valid);
        end
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
    endtask

    task automatic test_simultaneous();
        // A start-cycle bit that leaked in would misalign every later field.
        start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        step();
        start = 1'b0; bit_valid = 1'b0;
        tests++;
        if (state_out !== 3'd1) begin
            fails++;
            $display("FAIL start_with_bit_state: got st=%0d, want 1", state_out);
        end
        send_operand(8'h36, 0);
        send_operand(8'h9B, 0);
        send_bits(8'h03, 3, 0);
        tests++;
        if ({a_out, b_out, op_out, op_valid} !== {8'h36, 8'h9B, 3'd3, 1'b1}) begin
            fails++;
            $display("FAIL start_with_bit_issue: got a=%h b=%h op=%0d vld=%b, want a=36 b=9b op=3 vld=1",
                     a_out, b_out, op_out, op_valid);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        tests++;
        if ({op_valid, state_out, a_out} !== {1'b1, 3'd4, 8'h36}) begin
            fails++;
            $display("FAIL start_in_issue: got vld=%b st=%0d a=%h, want vld=1 st=4 a=36", op_valid, state_out, a_out);
        end
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        send_bits(8'h05, 3, 0);
        abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        step();
        abort = 1'b0; bit_valid = 1'b0;
        tests++;
        if ({state_out, busy, a_out} !== {3'd0, 1'b0, 8'h36}) begin
            fails++;
            $display("FAIL abort_with_bit: got st=%0d busy=%b a=%h, want st=0 busy=0 a=36", state_out, busy, a_out);
        end
        send_frame(8'hE1, 8'h4D, 3'b001, 0);
        tests++;
        if ({a_out, b_out, op_out, op_valid} !== {8'hE1, 8'h4D, 3'd1, 1'b1}) begin
            fails++;
            $display("FAIL abort_with_bit_reframe: got a=%h b=%h op=%0d vld=%b, want a=e1 b=4d op=1 vld=1",
                     a_out, b_out, op_out, op_valid);
        end
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        step();
        start = 1'b0;
        send_operand(8'h77, 0);
        send_operand(8'h88, 0);
        send_bit(1'b1, 0);
        tests++;
        if (state_out !== 3'd3) begin
            fails++;
            $display("FAIL reset_mid_pre: got st=%0d, want 3", state_out);
        end
        reset = 1'b1; abort = 1'b1; start = 1'b1;
        step();
        reset = 1'b0; abort = 1'b0; start = 1'b0;
        tests++;
        if ({a_out, b_out, op_out, op_valid, busy, err, state_out} !== 25'd0) begin
            fails++;
            $display("FAIL reset_mid_frame: got a=%h b=%h op=%0d vld=%b busy=%b err=%b st=%0d, want all 0",
                     a_out, b_out, op_out, op_valid, busy, err, state_out);
        end
        exp_a = 8'd0; exp_b = 8'd0; exp_op = 3'd0;
    endtask

`ifdef ALU_LOADER_PARITY_EN
    task automatic test_parity();
        start = 1'b1;
        step();
        start = 1'b0;
        send_bits(8'h07, 8, 0);
        send_bit(1'b1, 0);
        tests++;
        if ({state_out, err} !== {3'd2, 1'b0}) begin
            fails++;
            $display("FAIL parity_a_ok: got st=%0d err=%b, want st=2 err=0", state_out, err);
        end
        send_bits(8'h03, 8, 0);
        send_bit(1'b1, 0);
        tests++;
        if ({err, state_out, op_valid, busy} !== {1'b1, 3'd5, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL parity_b_err: got err=%b st=%0d vld=%b busy=%b, want err=1 st=5 vld=0 busy=0",
                     err, state_out, op_valid, busy);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        tests++;
        if ({err, state_out} !== {1'b0, 3'd1}) begin
            fails++;
            $display("FAIL parity_restart: got err=%b st=%0d, want err=0 st=1", err, state_out);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        int         hold;
        for (int f = 0; f < 20; f++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            op = 3'($urandom);
            hold = int'($urandom_range(0, 4));
            rnd_ready = 1'b1;
            send_frame(a, b, op, 3);
            rnd_ready = 1'b0;
            op_ready = 1'b0;
            for (int c = 0; c <= hold; c++) begin
                tests++;
                if ({a_out, b_out, op_out, op_valid, state_out} !== {exp_a, exp_b, exp_op, 1'b1, 3'd4}) begin
                    fails++;
                    $display("FAIL random_issue f%0d c%0d: got a=%h b=%h op=%0d vld=%b st=%0d, want a=%h b=%h op=%0d vld=1 st=4",
                             f, c, a_out, b_out, op_out, op_valid, state_out, exp_a, exp_b, exp_op);
                end
                if (c < hold) step();
            end
            op_ready = 1'b1;
            step();
            op_ready = 1'b0;
            tests++;
            if ({op_valid, state_out, a_out, b_out, op_out} !== {1'b0, 3'd0, exp_a, exp_b, exp_op}) begin
                fails++;
                $display("FAIL random_accept f%0d: got vld=%b st=%0d a=%h b=%h op=%0d, want vld=0 st=0 a=%h b=%h op=%0d",
                         f, op_valid, state_out, a_out, b_out, op_out, exp_a, exp_b, exp_op);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_abort();
        test_simultaneous();
        test_reset_mid();
`ifdef ALU_LOADER_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_operand_loader.md
ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

Interface
REQ-001 The block SHALL have a port `clk`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have a port `reset`: input, 1 bit, synchronous and active-high.
REQ-003 The block SHALL have a port `start`: input, 1 bit, begins a load frame.
REQ-004 The block SHALL have a port `abort`: input, 1 bit, cancels a frame in progress.
REQ-005 The block SHALL have a port `bit_in`: input, 1 bit, the serial data bit.
REQ-006 The block SHALL have a port `bit_valid`: input, 1 bit; `bit_in` is accepted on each clock edge where it is high.
REQ-007 The block SHALL have a port `op_ready`: input, 1 bit, the downstream ALU stage accepts the issued operands.
REQ-008 The block SHALL have a port `a_out`: output, 8 bits, operand A presented to the ALU.
REQ-009 The block SHALL have a port `b_out`: output, 8 bits, operand B presented to the ALU.
REQ-010 The block SHALL have a port `op_out`: output, 3 bits, the ALU opcode.
REQ-011 The block SHALL have a port `op_valid`: output, 1 bit, high while `a_out`/`b_out`/`op_out` form a pending issue.
REQ-012 The block SHALL have a port `busy`: output, 1 bit, high in LOAD_A, LOAD_B and LOAD_OP.
REQ-013 The block SHALL have a port `err`: output, 1 bit, the parity-error flag.
REQ-014 The block SHALL have a port `state_out`: output, 3 bits, the FSM state code: IDLE=0, LOAD_A=1, LOAD_B=2, LOAD_OP=3, ISSUE=4, ERR=5.

Function
REQ-015 The FSM SHALL transition IDLE -> LOAD_A on `start`; the bit counter and shift registers clear on that edge; a `bit_valid` in the same cycle SHALL NOT be captured.
REQ-016 Each accepted bit SHALL shift into the active shift register MSB-first: {sr[6:0], bit_in}.
REQ-017 The FSM SHALL leave LOAD_A for LOAD_B on the edge accepting the 8th A bit, with the counter reset to 0.
REQ-018 LOAD_B SHALL behave like LOAD_A and go to LOAD_OP after 8 bits.
REQ-019 LOAD_OP SHALL go to ISSUE after 3 bits.
REQ-020 On entry to ISSUE, `a_out`, `b_out` and `op_out` SHALL load from the shift registers, and `op_valid` SHALL rise the cycle after the final bit is accepted (1-cycle latency).
REQ-021 Outside that load, `a_out`, `b_out` and `op_out` SHALL hold their last issued values at all times.
REQ-022 In ISSUE, `op_valid` SHALL stay high with stable outputs until `op_valid` and `op_ready` are both high on one edge; the FSM then goes to IDLE and `op_valid` is low the next cycle.
REQ-023 `op_ready` SHALL be ignored outside ISSUE.
REQ-024 `abort` from any state other than IDLE SHALL force IDLE on the next edge: counter cleared, `op_valid`=0, `err`=0, and issued outputs unchanged.
REQ-025 `abort` SHALL take priority over `start`, `bit_valid` and `op_ready` in the same cycle.
REQ-026 `start` SHALL be ignored in LOAD_A, LOAD_B, LOAD_OP and ISSUE.
REQ-027 `bit_valid` SHALL be ignored in IDLE, ISSUE and ERR.
REQ-028 The bit counter SHALL be 4 bits wide and SHALL never exceed the field length minus 1; there is no wrap-around.

Reset
REQ-029 While `reset` is high at a clock edge, the next state SHALL be state=IDLE, the counter 0, both shift registers 0, `a_out`=0, `b_out`=0, `op_out`=0, `op_valid`=0, `busy`=0, `err`=0 and `state_out`=0.
REQ-030 `reset` SHALL override `abort`, `start` and data; a reset during a frame discards it.

Configuration
REQ-031 With `ALU_LOADER_PARITY_EN` defined, each 8-bit operand field SHALL be followed by one parity bit (even parity over the 9 bits).
REQ-032 With `ALU_LOADER_PARITY_EN` defined, an operand field SHALL therefore be 9 accepted bits, and the opcode field SHALL carry no parity bit.
REQ-033 With `ALU_LOADER_PARITY_EN` defined, a mismatch SHALL go to ERR on the edge the parity bit is accepted, with `err`=1 and `op_valid`=0.
REQ-034 ERR SHALL be left only by `abort` (to IDLE), `start` (to LOAD_A, with `err` cleared) or `reset`.
REQ-035 With `ALU_LOADER_PARITY_EN` undefined, there SHALL be no parity bits, so a frame is 19 bits, `err` is tied to 0 and ERR is unreachable.

Verification
REQ-036 The bench SHALL cover a basic frame: reset; `start`; serial A=0xA5, B=0x3C, op=3'b000; `op_ready`=0 -> `op_valid`=1 one cycle after the last bit with `a_out`=0xA5, `b_out`=0x3C, `op_out`=0, held 5 cycles; then `op_ready`=1 -> IDLE, `op_valid`=0 next cycle.
REQ-037 The bench SHALL cover gapped `bit_valid`: bits spaced with 0-3 idle cycles each, A=0xFF, B=0x01, op=3'b101 -> same values issued and `state_out` sequence 0,1,2,3,4.
REQ-038 The bench SHALL cover abort mid-B: after a prior issue of 0x11/0x22, send A=0x80 and 4 bits of B, then `abort` -> IDLE next cycle, `a_out`=0x11, `b_out`=0x22, `op_valid`=0; a new full frame then issues correctly.
REQ-039 The bench SHALL cover simultaneous events: `start` with `bit_valid` in IDLE (bit not captured); `abort` with `bit_valid` in LOAD_A (IDLE, no shift); `start` in ISSUE (ignored, `op_valid` stays 1).
REQ-040 The bench SHALL cover reset mid-frame: `reset` pulsed during LOAD_OP -> all outputs 0 and `state_out`=0 the next cycle.
REQ-041 The bench SHALL cover parity, with `ALU_LOADER_PARITY_EN` defined: A=0x07 with parity 1 and B=0x03 with parity 1 -> `err`=1 and `state_out`=5 after the B parity bit; then `start` -> `err`=0 and `state_out`=1.
